// File: rtl/mem_1w1r_fifo_ctrl.sv
// mem_1w1r_fifo_ctrl: FIFO controller for an external 1-write/1-read memory with a 2-entry registered output buffer
//   clk, rst                          : clock and synchronous active-high reset
//   flush                             : synchronous clear of all contents
//   wr_valid, wr_ready, wr_data       : write handshake and payload
//   rd_valid, rd_ready, rd_data       : read handshake and head payload
//   level                             : registered total entries held (memory + in flight + buffer)
//   mem_wen, mem_waddr, mem_wdata     : memory write port
//   mem_ren, mem_raddr, mem_rdata     : memory read port, mem_rdata valid the cycle after mem_ren
module mem_1w1r_fifo_ctrl #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 39,
    parameter int DEPTH      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_WIDTH+1:0]  level,
    output logic                  mem_wen,
    output logic [PTR_WIDTH-1:0]  mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ren,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH:0]   FULL = (PTR_WIDTH + 1)'(DEPTH);
    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_WIDTH:0]    mem_cnt_q, mem_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_cnt_q, ob_cnt_d, ob_left;
    logic [DATA_WIDTH-1:0] ob0_q, ob0_d, ob1_q, ob1_d, ob_shift;
    logic [PTR_WIDTH+1:0]  level_q, level_d;
    logic                  push, pop, fetch, cap;
    always_comb begin
        wr_ready   = !rst && !flush && mem_cnt_q != FULL;
        rd_valid   = !rst && ob_cnt_q != 2'd0;
        rd_data    = ob0_q;
        level      = level_q;
        push       = wr_valid && wr_ready;
        pop        = rd_valid && rd_ready;
        // fetch only if the buffer can absorb the word once it returns
        fetch      = !rst && !flush && mem_cnt_q != '0 &&
                     ({1'b0, ob_cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
        cap        = inflight_q && !flush;
        mem_wen    = push;
        mem_waddr  = wptr_q;
        mem_wdata  = wr_data;
        mem_ren    = fetch;
        mem_raddr  = rptr_q;
        ob_left    = ob_cnt_q - {1'b0, pop};
        ob_shift   = pop ? ob1_q : ob0_q;
        ob0_d      = (cap && ob_left == 2'd0) ? mem_rdata : ob_shift;
        ob1_d      = (cap && ob_left == 2'd1) ? mem_rdata : ob1_q;
        wptr_d     = flush ? '0 : push  ? (wptr_q == LAST ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d     = flush ? '0 : fetch ? (rptr_q == LAST ? '0 : rptr_q + 1'b1) : rptr_q;
        mem_cnt_d  = flush ? '0 : mem_cnt_q + {PTR_WIDTH'(0), push} - {PTR_WIDTH'(0), fetch};
        inflight_d = fetch;
        ob_cnt_d   = flush ? 2'd0 : ob_left + {1'b0, cap};
        level_d    = {1'b0, mem_cnt_d} + {{(PTR_WIDTH + 1){1'b0}}, inflight_d} +
                     {{PTR_WIDTH{1'b0}}, ob_cnt_d};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            ob0_q      <= '0;
            ob1_q      <= '0;
            level_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            ob_cnt_q   <= ob_cnt_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
            level_q    <= level_d;
        end
    end
endmodule

// File: tb/tb_mem_1w1r_fifo_ctrl.sv
// tb_mem_1w1r_fifo_ctrl: scoreboard bench for mem_1w1r_fifo_ctrl with a behavioural 1W1R memory
module tb_mem_1w1r_fifo_ctrl;
    localparam int PW = 3;
    localparam int DW = 39;
    localparam int DP = 7;
    logic          clk = 1'b0;
    logic          rst, flush, wr_valid, rd_ready;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_valid, mem_wen, mem_ren;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
    logic [PW+1:0] level;
    logic [PW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem [0:DP-1];
    logic [DW-1:0] sb [$];
    int            total = 0;
    int            bad = 0;
    int            ref_level = 0;
    int            exp_waddr = 0;
    int            exp_raddr = 0;

    mem_1w1r_fifo_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // read data is poisoned whenever no read was issued, so stale captures show up
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem_ren ? mem[mem_raddr] : 39'h5A5A5A5A5A;
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        chk("level_ref", 64'(level), 64'(ref_level));
        if (mem_wen) chk("waddr_seq", 64'(mem_waddr), 64'(exp_waddr));
        if (mem_ren) chk("raddr_seq", 64'(mem_raddr), 64'(exp_raddr));
        if (rd_valid && rd_ready) begin
            if (sb.size() == 0) chk("pop_empty_sb", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("rd_data_order", 64'(rd_data), 64'(sb.pop_front()));
        end
        if (rst || flush) begin
            sb.delete();
            ref_level = 0;
            exp_waddr = 0;
            exp_raddr = 0;
        end else begin
            if (wr_valid && wr_ready) sb.push_back(wr_data);
            ref_level += int'(wr_valid && wr_ready) - int'(rd_valid && rd_ready);
            if (mem_wen) exp_waddr = (exp_waddr == DP - 1) ? 0 : exp_waddr + 1;
            if (mem_ren) exp_raddr = (exp_raddr == DP - 1) ? 0 : exp_raddr + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        mid;
        while (level != 0 && n < 60) begin
            step;
            mid;
            n++;
        end
        chk(nm, 64'(level), 64'd0);
        chk({nm, "_sb"}, 64'(sb.size()), 64'd0);
        step;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        wr_data = '0;
        step;
        step;
        mid;
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        step;
        rst = 1'b0;
        wr_valid = 1'b0;
        mid;
        chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("post_rst_level", 64'(level), 64'd0);
        step;
        // single push latency: push T, fetch T+1, capture T+2, visible T+3
        wr_valid = 1'b1;
        wr_data = 39'h15;
        mid;
        chk("lat_wr_ready", 64'(wr_ready), 64'd1);
        chk("lat_t0_rd_valid", 64'(rd_valid), 64'd0);
        step;
        wr_valid = 1'b0;
        mid;
        chk("lat_t1_level", 64'(level), 64'd1);
        chk("lat_t1_mem_ren", 64'(mem_ren), 64'd1);
        chk("lat_t1_rd_valid", 64'(rd_valid), 64'd0);
        step;
        mid;
        chk("lat_t2_level", 64'(level), 64'd1);
        chk("lat_t2_rd_valid", 64'(rd_valid), 64'd0);
        step;
        mid;
        chk("lat_t3_rd_valid", 64'(rd_valid), 64'd1);
        chk("lat_t3_rd_data", 64'(rd_data), 64'h15);
        chk("lat_t3_level", 64'(level), 64'd1);
        step;
        mid;
        chk("lat_t4_rd_valid", 64'(rd_valid), 64'd0);
        chk("lat_t4_level", 64'(level), 64'd0);
        step;
        flush = 1'b1;
        mid;
        chk("flush_wr_ready", 64'(wr_ready), 64'd0);
        step;
        flush = 1'b0;
        // fill to DEPTH+2 with no consumer, then one pop frees a memory slot
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data = DW'(39'h100 + i);
            mid;
            chk($sformatf("fill_wr_ready_%0d", i), 64'(wr_ready), 64'd1);
            step;
        end
        wr_data = 39'h109;
        for (int i = 0; i < 3; i++) begin
            mid;
            chk("full_wr_ready", 64'(wr_ready), 64'd0);
            chk("full_level", 64'(level), 64'd9);
            chk("hold_rd_valid", 64'(rd_valid), 64'd1);
            chk("hold_rd_data", 64'(rd_data), 64'h100);
            step;
        end
        rd_ready = 1'b1;
        mid;
        chk("pop_cycle_wr_ready", 64'(wr_ready), 64'd0);
        step;
        rd_ready = 1'b0;
        mid;
        chk("after_pop_wr_ready", 64'(wr_ready), 64'd1);
        step;
        wr_valid = 1'b0;
        mid;
        chk("refill_level", 64'(level), 64'd9);
        step;
        drain("drain_full");
        flush = 1'b1;
        step;
        flush = 1'b0;
        // streaming: one push and one pop per cycle, addresses wrap at DEPTH-1
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = DW'(39'h200 + i);
            mid;
            chk("stream_wr_ready", 64'(wr_ready), 64'd1);
            chk("stream_mem_wen", 64'(mem_wen), 64'd1);
            chk($sformatf("stream_waddr_%0d", i), 64'(mem_waddr), 64'(i % DP));
            step;
        end
        drain("drain_stream");
        // flush while a fetched word is still in flight
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data = DW'(39'h300 + i);
            step;
        end
        wr_valid = 1'b0;
        step;
        rd_ready = 1'b1;
        mid;
        chk("pre_flush_rd_valid", 64'(rd_valid), 64'd1);
        chk("pre_flush_mem_ren", 64'(mem_ren), 64'd1);
        step;
        rd_ready = 1'b0;
        flush = 1'b1;
        step;
        flush = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid;
            chk("post_flush_level", 64'(level), 64'd0);
            chk("post_flush_rd_valid", 64'(rd_valid), 64'd0);
            step;
        end
        // reset pulse mid-stream
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = DW'(39'h400 + i);
            step;
        end
        rst = 1'b1;
        wr_data = 39'h40A;
        mid;
        chk("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("mid_rst_mem_ren", 64'(mem_ren), 64'd0);
        step;
        rst = 1'b0;
        wr_data = 39'h40B;
        mid;
        chk("after_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("after_rst_waddr", 64'(mem_waddr), 64'd0);
        chk("after_rst_level", 64'(level), 64'd0);
        step;
        drain("drain_rst");
        // random backpressure
        for (int i = 0; i < 10000; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            wr_data = DW'({$urandom, $urandom});
            step;
        end
        drain("drain_random");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
